uart_tx_port: RTL and testbench

// Memory-mapped UART transmitter that sits downstream of the CPU store path, next to the parallel output port.
// - Decodes the same Address/WD/WE bus the data memory sees.
// - A store to TX_ADDR pushes one byte into a small FIFO.
// - An 8N1 serializer (8E1 when parity is enabled) drains the FIFO onto UART_TXD.
// - A load from STAT_ADDR returns busy/full/overflow status through the parallel input read mux.

---
 rtl/uart_tx_port_if.sv | 9 +
 rtl/uart_tx_port.sv | 138 +++++++++++++
 tb/tb_uart_tx_port.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU store/load bus seen by the UART transmitter port
interface uart_tx_port_if;
    logic [7:0] Address;
    logic [7:0] WD;
    logic       WE;
    logic [7:0] RD;
    modport master (output Address, output WD, output WE, input RD);
    modport slave  (input Address, input WD, input WE, output RD);
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter (FIFO + 8N1 serializer); define UART_TX_PARITY_EN for 8E1 framing
module uart_tx_port #(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] TX_ADDR   = 8'hFC,
    parameter logic [7:0] STAT_ADDR = 8'hFD
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_port_if.slave bus,
    output logic          TXD,
    output logic          Busy,
    output logic          Full
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0] T_MAX    = TW'(CPB - 1);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          ovf, txd_n, push, pop, tick_end;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign tick_end = timer == T_MAX;
    assign Full     = count == FULL_CNT;
    assign Busy     = state != IDLE || count != '0;
    assign push     = bus.WE && bus.Address == TX_ADDR && !Full;
    assign pop      = state == IDLE && count != '0;
    assign bus.RD   = bus.Address == STAT_ADDR ? {5'b0, ovf, Full, Busy} : 8'h00;

    // FIFO data array; storage needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.WD;
    end

    // FIFO pointers, occupancy and sticky overflow (set by a store while full, cleared by a store to status)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (bus.WE && bus.Address == TX_ADDR && Full) ovf <= 1'b1;
            else if (bus.WE && bus.Address == STAT_ADDR) ovf <= 1'b0;
        end
    end

    // serializer state; reset forces the line idle at once, aborting any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            TXD     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            TXD     <= txd_n;
`ifdef UART_TX_PARITY_EN
            if (pop) par <= ^mem[rp];
`endif
        end
    end

    // next-state and next line level; the bit timer restarts on every bit boundary
    always_comb begin
        state_n   = state;
        timer_n   = tick_end ? '0 : timer + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        txd_n     = TXD;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (pop) begin
                    state_n = START;
                    shreg_n = mem[rp];
                    txd_n   = 1'b0;
                end
            end
            START: if (tick_end) begin
                state_n   = DATA;
                bit_idx_n = '0;
                txd_n     = shreg[0];
            end
            DATA: if (tick_end) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    txd_n   = par;
`else
                    state_n = STOP;
                    txd_n   = 1'b1;
`endif
                end else begin
                    bit_idx_n = bit_idx + 1'b1;
                    shreg_n   = shreg >> 1;
                    txd_n     = shreg[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick_end) begin
                state_n = STOP;
                txd_n   = 1'b1;
            end
`endif
            STOP: if (tick_end) begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: self-checking bench for uart_tx_port (8 clocks/bit, 4-entry FIFO)
module tb_uart_tx_port;
    localparam int         CPB   = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] TXA   = 8'hFC;
    localparam logic [7:0] STA   = 8'hFD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, busy, full;
    uart_tx_port_if bus();

    uart_tx_port #(.CLK_FREQ(8), .BAUD(1), .DEPTH(DEPTH), .TX_ADDR(TXA), .STAT_ADDR(STA)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .TXD(txd), .Busy(busy), .Full(full)
    );

    // free-running clock
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: pending bytes, current frame start time and byte, sticky overflow
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic       m_fr, m_ovf;
    logic [7:0] m_byte;
    int         cyc, m_start;

    // independent line receiver: samples TXD mid-bit, pushes {stop_error, byte}
    logic [8:0] rx_q[$];
    logic       rx_on;
    int         rx_cnt;
    logic [7:0] rx_sh;

    // UART receiver sampling on the falling clock edge
    always @(negedge clk) begin
        if (!rst) rx_on <= 1'b0;
        else if (!rx_on) begin
            if (!txd) begin
                rx_on  <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] <= txd;
                if (rx_cnt / CPB == FB - 1) begin
                    rx_q.push_back({!txd, rx_sh});
                    rx_on <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_txd();
        int k;
        if (!m_fr) return 1'b1;
        k = (cyc - m_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k - 1];
        if (k == 9 && FB == 11) return ^m_byte;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fr    = 1'b0;
        m_ovf   = 1'b0;
        cyc     = 0;
        m_start = 0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] a, input logic [7:0] d);
        logic full_b;
        cyc++;
        full_b = mq.size() == DEPTH;
        if (m_fr) begin
            if (cyc == m_start + FB * CPB) m_fr = 1'b0;
        end else if (mq.size() > 0) begin
            m_byte  = mq.pop_front();
            m_start = cyc;
            m_fr    = 1'b1;
            sent.push_back(m_byte);
        end
        if (we && a == TXA) begin
            if (full_b) m_ovf = 1'b1;
            else mq.push_back(d);
        end
        if (we && a == STA) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        logic mb, mf;
        mb = m_fr || mq.size() != 0;
        mf = mq.size() == DEPTH;
        chk("txd", txd, m_txd());
        chk("busy", busy, mb);
        chk("full", full, mf);
        chk("rd", bus.RD, bus.Address == STA ? {5'b0, m_ovf, mf, mb} : 8'h00);
    endtask

    task automatic tick(input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.WE      = we;
        bus.Address = a;
        bus.WD      = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        bus.WE      = 1'b0;
        bus.Address = STA;
        bus.WD      = 8'h00;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1'b0, STA, 8'h00);
            k++;
        end
        chk("drain_timeout", busy, 1'b0);
    endtask

    task automatic chk_rx(input string name, input int mark, input logic [7:0] exp[$]);
        chk({name, "_count"}, rx_q.size() - mark, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (mark + i < rx_q.size()) chk(name, rx_q[mark + i], {1'b0, exp[i]});
    endtask

    logic wave [0:127];

    task automatic send_cap(input logic [7:0] d, output int nb);
        tick(1'b1, TXA, d);
        nb = busy ? 1 : 0;
        for (int j = 0; j < FB * CPB + 4; j++) begin
            tick(1'b0, STA, 8'h00);
            wave[j] = txd;
            if (busy) nb++;
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
        logic       full;
    } vec_t;

    // bound on total run time
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tv[9];
        int         mark, smark, nb;
        logic [10:0] pat;
        logic [7:0] exp_q[$];
        tv[0] = '{1'b1, TXA, 8'h01, 8'h00, 1'b0};
        tv[1] = '{1'b1, TXA, 8'h02, 8'h00, 1'b0};
        tv[2] = '{1'b1, TXA, 8'h03, 8'h00, 1'b0};
        tv[3] = '{1'b1, TXA, 8'h04, 8'h00, 1'b0};
        tv[4] = '{1'b1, TXA, 8'h05, 8'h00, 1'b1};
        tv[5] = '{1'b1, TXA, 8'h06, 8'h00, 1'b1};
        tv[6] = '{1'b0, STA, 8'h00, 8'h07, 1'b1};
        tv[7] = '{1'b1, STA, 8'h5A, 8'h03, 1'b1};
        tv[8] = '{1'b0, TXA, 8'h00, 8'h00, 1'b1};

        do_reset();
        chk("reset_txd", txd, 1'b1);
        chk("reset_rd", bus.RD, 8'h00);

        mark = rx_q.size();
        send_cap(8'hA5, nb);
        pat = {1'b1, (FB == 11 ? 1'b0 : 1'b1), 8'hA5, 1'b0};
        for (int b = 0; b < FB; b++) chk($sformatf("t1_bit%0d", b), wave[b * CPB + CPB / 2], pat[b]);
        chk("t1_busy_len", nb, FB * CPB + 1);
        exp_q = '{8'hA5};
        chk_rx("t1_rx", mark, exp_q);

        do_reset();
        mark = rx_q.size();
        for (int i = 0; i < 9; i++) begin
            tick(tv[i].we, tv[i].addr, tv[i].wd);
            chk($sformatf("t2_rd%0d", i), bus.RD, tv[i].rd);
            chk($sformatf("t2_full%0d", i), full, tv[i].full);
        end
        drain(1000);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_rx("t2_rx", mark, exp_q);

        do_reset();
        tick(1'b1, TXA, 8'hC1);
        tick(1'b1, TXA, 8'hC2);
        tick(1'b1, TXA, 8'hC3);
        repeat (34) tick(1'b0, STA, 8'h00);
        chk("t4_bit3_low", txd, 1'b0);
        do_reset();
        chk("t4_txd_async", txd, 1'b1);
        chk("t4_rd", bus.RD, 8'h00);
        mark = rx_q.size();
        repeat (200) tick(1'b0, STA, 8'h00);
        chk("t4_no_frames", rx_q.size() - mark, 0);
        chk("t4_idle_busy", busy, 1'b0);

        do_reset();
        mark = rx_q.size();
        tick(1'b1, TXA, 8'h11);
        tick(1'b1, TXA, 8'h3C);
        chk("t5_busy", busy, 1'b1);
        chk("t5_full", full, 1'b0);
        tick(1'b1, TXA, 8'hA1);
        tick(1'b1, TXA, 8'hA2);
        chk("t5_full3", full, 1'b0);
        tick(1'b1, TXA, 8'hA3);
        chk("t5_full4", full, 1'b1);
        drain(1000);
        exp_q = '{8'h11, 8'h3C, 8'hA1, 8'hA2, 8'hA3};
        chk_rx("t5_rx", mark, exp_q);

`ifdef UART_TX_PARITY_EN
        do_reset();
        send_cap(8'h07, nb);
        chk("t6_par07", wave[9 * CPB + CPB / 2], 1'b1);
        chk("t6_len", nb, 89);
        send_cap(8'h03, nb);
        chk("t6_par03", wave[9 * CPB + CPB / 2], 1'b0);
`endif

        do_reset();
        mark  = rx_q.size();
        smark = sent.size();
        repeat (1500) begin
            int         r;
            logic [7:0] a;
            r = $urandom_range(0, 3);
            a = r < 2 ? TXA : (r == 2 ? STA : 8'($urandom));
            tick($urandom_range(0, 3) == 0, a, 8'($urandom));
        end
        drain(1500);
        exp_q.delete();
        for (int i = smark; i < sent.size(); i++) exp_q.push_back(sent[i]);
        chk_rx("rand_rx", mark, exp_q);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
